// File: rtl/pixel_stream_source_pkg.sv
// Shared definitions for the pixel stream source: register map, pattern codes,
// LFSR constants and FSM encoding.
package pixel_stream_source_pkg;

  localparam logic [4:0] ADDR_CTRL        = 5'h00;
  localparam logic [4:0] ADDR_PATTERN     = 5'h01;
  localparam logic [4:0] ADDR_CONST       = 5'h02;
  localparam logic [4:0] ADDR_GAP         = 5'h03;
  localparam logic [4:0] ADDR_STATUS      = 5'h10;
  localparam logic [4:0] ADDR_FRAME_COUNT = 5'h11;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_ABORT_BIT = 2;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'b00,
    PAT_CHECKER = 2'b01,
    PAT_CONST   = 2'b10,
    PAT_LFSR    = 2'b11
  } pattern_e;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam int         LFSR_TAP_A = 7;
  localparam int         LFSR_TAP_B = 5;
  localparam int         LFSR_TAP_C = 4;
  localparam int         LFSR_TAP_D = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/pixel_stream_source_pattern_gen.sv
// Pixel value generator: owns the frame LFSR and selects the pattern value
// for the current raster position.
module pixel_pattern_gen
  import pixel_stream_source_pkg::*;
#(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pattern_e      pattern,
  input  logic [7:0]    const_value,
  input  logic          advance,
  input  logic          reseed,
  output logic [7:0]    pixel
);

  logic [7:0] lfsr_q;
  logic       checker_on;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Bit 3 of x^y equals ((x>>3)^(y>>3))&1, i.e. alternate 8x8 tiles.
  assign checker_on = |((16'(x) ^ 16'(y)) & 16'h0008);

  // NOTE: a default assignment before the case keeps combinational blocks
  // free of inferred latches.
  always_comb begin
    pixel = 8'h00;
    unique case (pattern)
      PAT_RAMP:    pixel = 8'(x) + 8'(y);
      PAT_CHECKER: pixel = checker_on ? 8'hFF : 8'h00;
      PAT_CONST:   pixel = const_value;
      PAT_LFSR:    pixel = lfsr_q;
      default:     pixel = 8'h00;
    endcase
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Raster test-frame transmitter with a byte-wide register port; emits one
// pixel per STREAM cycle, separated by programmable idle gaps.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  reg_write_en,
  input  logic [4:0]            reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [7:0]    gap_cnt_q;
  logic          cont_q, done_q;
  pattern_e      pattern_q, sh_pattern_q;
  logic [7:0]    const_q, sh_const_q;
  logic [7:0]    gap_q, sh_gap_q;
  logic [7:0]    frame_count_q;
  logic [7:0]    pixel;

  logic wr_ctrl, start_req, abort_req, busy;
  logic last_x, last_y, last_pix;
  logic emit, do_start, do_abort, restart, finish, load_shadow;
  logic [7:0] next_gap;

  assign wr_ctrl   = reg_write_en && (reg_addr == ADDR_CTRL);
  assign start_req = wr_ctrl && reg_wdata[CTRL_START_BIT];
  assign abort_req = wr_ctrl && reg_wdata[CTRL_ABORT_BIT];
  assign busy      = (state_q != ST_IDLE);

  assign last_x   = (x_q == X_LAST);
  assign last_y   = (y_q == Y_LAST);
  assign last_pix = last_x && last_y;

  // Abort beats start, and beats the pixel that would have been emitted.
  assign emit        = (state_q == ST_STREAM) && !abort_req;
  assign do_start    = !busy && start_req && !abort_req;
  assign do_abort    = busy && abort_req;
  assign restart     = emit && last_pix && cont_q;
  assign finish      = emit && last_pix && !cont_q;
  assign load_shadow = do_start || restart;
  assign next_gap    = restart ? gap_q : sh_gap_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (do_start) state_d = ST_STREAM;
      ST_STREAM: begin
        if (do_abort || finish) state_d = ST_IDLE;
        else if (next_gap != 8'd0) state_d = ST_GAP;
        else state_d = ST_STREAM;
      end
      ST_GAP: begin
        if (do_abort) state_d = ST_IDLE;
        else if (gap_cnt_q <= 8'd1) state_d = ST_STREAM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every flop, including config and shadow copies, sits on the
  // async reset so a mid-frame reset leaves no stale configuration behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q           <= '0;
      y_q           <= '0;
      gap_cnt_q     <= 8'd0;
      cont_q        <= 1'b0;
      done_q        <= 1'b0;
      pattern_q     <= PAT_RAMP;
      const_q       <= 8'd0;
      gap_q         <= 8'd0;
      sh_pattern_q  <= PAT_RAMP;
      sh_const_q    <= 8'd0;
      sh_gap_q      <= 8'd0;
      frame_count_q <= 8'd0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sof       <= 1'b0;
      out_eol       <= 1'b0;
      out_eof       <= 1'b0;
    end else begin
      if (reg_write_en) begin
        unique case (reg_addr)
          ADDR_CTRL:    cont_q    <= reg_wdata[CTRL_CONT_BIT];
          ADDR_PATTERN: pattern_q <= pattern_e'(reg_wdata[1:0]);
          ADDR_CONST:   const_q   <= reg_wdata;
          ADDR_GAP:     gap_q     <= reg_wdata;
          default: ;
        endcase
      end

      if (load_shadow) begin
        sh_pattern_q <= pattern_q;
        sh_const_q   <= const_q;
        sh_gap_q     <= gap_q;
      end

      if (do_start) done_q <= 1'b0;
      else if (finish) done_q <= 1'b1;

      if (emit && last_pix) frame_count_q <= frame_count_q + 8'd1;

      if (do_start || do_abort) begin
        x_q <= '0;
        y_q <= '0;
      end else if (emit) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      if (emit) gap_cnt_q <= next_gap;
      else if (state_q == ST_GAP && gap_cnt_q != 8'd0) gap_cnt_q <= gap_cnt_q - 8'd1;

      out_valid <= emit;
      out_data  <= emit ? DATA_WIDTH'(pixel) : '0;
      out_sof   <= emit && (x_q == '0) && (y_q == '0);
      out_eol   <= emit && last_x;
      out_eof   <= emit && last_pix;
    end
  end

  pixel_pattern_gen #(
    .XW (XW),
    .YW (YW)
  ) u_pattern_gen (
    .clk         (clk),
    .rstn        (rstn),
    .x           (x_q),
    .y           (y_q),
    .pattern     (sh_pattern_q),
    .const_value (sh_const_q),
    .advance     (emit),
    .reseed      (load_shadow),
    .pixel       (pixel)
  );

  always_comb begin
    reg_rdata = 8'h00;
    unique case (reg_addr)
      ADDR_CTRL:        reg_rdata = {6'b0, cont_q, 1'b0};
      ADDR_PATTERN:     reg_rdata = {6'b0, pattern_q};
      ADDR_CONST:       reg_rdata = const_q;
      ADDR_GAP:         reg_rdata = gap_q;
      ADDR_STATUS:      reg_rdata = {6'b0, done_q, busy};
      ADDR_FRAME_COUNT: reg_rdata = frame_count_q;
      default:          reg_rdata = 8'h00;
    endcase
  end

endmodule
